// File: rtl/mch_tx_arb.sv
// Round-robin two-requester frame scheduler for the Manchester transmit path.
// Optional WAIT_DONE watchdog enabled by defining MCH_ARB_WDOG_EN.
module mch_tx_arb #(
  parameter int DW       = 56,
  parameter int GAP_CYC  = 100,
  parameter int ACK_TMO  = 8,
  parameter int WDOG_CYC = 8191
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [DW-1:0] data0,
  output logic          gnt0,
  output logic          done0,
  input  logic          req1,
  input  logic [DW-1:0] data1,
  output logic          gnt1,
  output logic          done1,
  output logic          enc_start,
  output logic [DW-1:0] enc_data,
  input  logic [1:0]    enc_stm,
  output logic          busy,
  output logic          err
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  localparam int ACK_CW = $clog2((ACK_TMO > 2) ? ACK_TMO : 2) + 1;
  localparam int GAP_CW = $clog2((GAP_CYC > 2) ? GAP_CYC : 2) + 1;
  localparam logic [ACK_CW-1:0] ACK_LIM = ACK_CW'((ACK_TMO > 0) ? ACK_TMO - 1 : 0);
  // GAP_CYC of 0 and 1 both leave GAP after a single cycle
  localparam logic [GAP_CW-1:0] GAP_LIM = GAP_CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t              state_r, state_s;
  logic                win_r, win_s;
  logic                last_r, last_s;
  logic [ACK_CW-1:0]   ack_cnt_r, ack_cnt_s;
  logic [GAP_CW-1:0]   gap_cnt_r, gap_cnt_s;
  logic [DW-1:0]       enc_data_r, enc_data_s;
  logic                gnt0_r, gnt0_s, gnt1_r, gnt1_s;
  logic                done0_r, done0_s, done1_r, done1_s;
  logic                start_r, start_s;
  logic                busy_r, busy_s;
  logic                err_r, err_s;
  logic                pick_s;

`ifdef MCH_ARB_WDOG_EN
  localparam int WD_CW = $clog2((WDOG_CYC > 2) ? WDOG_CYC : 2) + 1;
  localparam logic [WD_CW-1:0] WD_LIM = WD_CW'((WDOG_CYC > 0) ? WDOG_CYC - 1 : 0);
  logic [WD_CW-1:0] wdog_cnt_r, wdog_cnt_s;
`endif

  // Requester selection: a lone request wins, a tie goes to the one not served last
  always_comb begin
    pick_s = 1'b0;
    if (req0 && req1) begin
      pick_s = ~last_r;
    end else begin
      pick_s = req1;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_s    = state_r;
    win_s      = win_r;
    last_s     = last_r;
    ack_cnt_s  = ack_cnt_r;
    gap_cnt_s  = gap_cnt_r;
    enc_data_s = enc_data_r;
    gnt0_s     = 1'b0;
    gnt1_s     = 1'b0;
    done0_s    = 1'b0;
    done1_s    = 1'b0;
    start_s    = 1'b0;
    err_s      = err_r;
`ifdef MCH_ARB_WDOG_EN
    wdog_cnt_s = wdog_cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (req0 || req1) begin
          win_s      = pick_s;
          enc_data_s = pick_s ? data1 : data0;
          gnt0_s     = ~pick_s;
          gnt1_s     = pick_s;
          state_s    = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        start_s   = 1'b1;
        ack_cnt_s = '0;
        state_s   = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (enc_stm != 2'd3) begin
`ifdef MCH_ARB_WDOG_EN
          wdog_cnt_s = '0;
`endif
          state_s = ST_WAIT_DONE;
        end else if (ack_cnt_r >= ACK_LIM) begin
          err_s     = 1'b1;
          last_s    = win_r;
          gap_cnt_s = '0;
          state_s   = ST_GAP;
        end else begin
          ack_cnt_s = ack_cnt_r + {{(ACK_CW-1){1'b0}}, 1'b1};
        end
      end
      ST_WAIT_DONE: begin
        if (enc_stm == 2'd3) begin
          done0_s   = ~win_r;
          done1_s   = win_r;
          last_s    = win_r;
          gap_cnt_s = '0;
          state_s   = ST_GAP;
        end else begin
`ifdef MCH_ARB_WDOG_EN
          if (wdog_cnt_r >= WD_LIM) begin
            err_s     = 1'b1;
            last_s    = win_r;
            gap_cnt_s = '0;
            state_s   = ST_GAP;
          end else begin
            wdog_cnt_s = wdog_cnt_r + {{(WD_CW-1){1'b0}}, 1'b1};
          end
`else
          state_s = ST_WAIT_DONE;
`endif
        end
      end
      ST_GAP: begin
        if (gap_cnt_r >= GAP_LIM) begin
          state_s = ST_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + {{(GAP_CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State, counters and all output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      win_r      <= 1'b0;
      last_r     <= 1'b1;
      ack_cnt_r  <= '0;
      gap_cnt_r  <= '0;
      enc_data_r <= '0;
      gnt0_r     <= 1'b0;
      gnt1_r     <= 1'b0;
      done0_r    <= 1'b0;
      done1_r    <= 1'b0;
      start_r    <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
`ifdef MCH_ARB_WDOG_EN
      wdog_cnt_r <= '0;
`endif
    end else begin
      state_r    <= state_s;
      win_r      <= win_s;
      last_r     <= last_s;
      ack_cnt_r  <= ack_cnt_s;
      gap_cnt_r  <= gap_cnt_s;
      enc_data_r <= enc_data_s;
      gnt0_r     <= gnt0_s;
      gnt1_r     <= gnt1_s;
      done0_r    <= done0_s;
      done1_r    <= done1_s;
      start_r    <= start_s;
      busy_r     <= busy_s;
      err_r      <= err_s;
`ifdef MCH_ARB_WDOG_EN
      wdog_cnt_r <= wdog_cnt_s;
`endif
    end
  end

  assign gnt0      = gnt0_r;
  assign gnt1      = gnt1_r;
  assign done0     = done0_r;
  assign done1     = done1_r;
  assign enc_start = start_r;
  assign enc_data  = enc_data_r;
  assign busy      = busy_r;
  assign err       = err_r;

endmodule
